// File: rtl/approx_mac_pkg.sv
// Shared types and helpers for the approximate-MAC accumulate datapaths.
// Both the unsigned accumulator and the planned signed variant use them.
package approx_mac_pkg;

  localparam int DEF_PROD_W = 16;
  localparam int SAT_MAX_W  = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  typedef struct packed {
    logic                 ovf;
    logic [SAT_MAX_W-1:0] sum;
  } sat_res_t;

  // Unsigned add clamped to (2^width - 1); both operands must already fit in width bits.
  function automatic sat_res_t sat_add(input logic [SAT_MAX_W-1:0] acc,
                                       input logic [SAT_MAX_W-1:0] prod,
                                       input int unsigned          width);
    logic [SAT_MAX_W:0] full;
    logic [SAT_MAX_W:0] limit;
    sat_res_t           res;
    full    = {1'b0, acc} + {1'b0, prod};
    limit   = ((SAT_MAX_W + 1)'(1) << width) - (SAT_MAX_W + 1)'(1);
    res.ovf = (full > limit);
    res.sum = res.ovf ? limit[SAT_MAX_W-1:0] : full[SAT_MAX_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/approx_sat_add.sv
// Combinational ACC_W-bit saturating adder; the product is zero-extended
// and any carry out of the accumulator width clamps the sum to all-ones.
module approx_sat_add
  import approx_mac_pkg::*;
#(
  parameter int ACC_W  = 24,
  parameter int PROD_W = DEF_PROD_W
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_prod,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_ovf
);

  sat_res_t w_res;
  logic     w_unused_hi;

  assign w_res       = sat_add(SAT_MAX_W'(i_acc), SAT_MAX_W'(i_prod), ACC_W);
  assign o_sum       = w_res.sum[ACC_W-1:0];
  assign o_ovf       = w_res.ovf;
  // Bits above ACC_W are always zero after clamping.
  assign w_unused_hi = |w_res.sum[SAT_MAX_W-1:ACC_W];

endmodule

// File: rtl/approx_prod_accumulator.sv
// Accumulates runs of approximate-multiplier products into a saturated sum,
// handing the sum, beat count and status flags downstream over valid/ready.
module approx_prod_accumulator
  import approx_mac_pkg::*;
#(
  parameter int   PROD_W  = DEF_PROD_W,
  parameter int   ACC_W   = 24,
  parameter int   MAX_LEN = 256,
  localparam int  CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_last,
  output logic              prod_ready,
  output logic              acc_valid,
  output logic [ACC_W-1:0]  acc_data,
  output logic [CNT_W-1:0]  acc_count,
  output logic              acc_overflow,
  output logic              acc_truncated,
  input  logic              out_ready
);

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_trunc;
  logic             r_valid;

  logic             w_beat;
  logic             w_consume;
  logic             w_start;
  logic [ACC_W-1:0] w_sum;
  logic             w_ovf;
  logic [CNT_W-1:0] w_next_count;

  // In HOLD a beat is only taken together with a consume, so runs chain with no bubble.
  assign prod_ready   = (r_state != HOLD) | out_ready;
  assign w_beat       = prod_valid & prod_ready;
  assign w_consume    = r_valid & out_ready;
  assign w_start      = w_beat & (r_state != ACCUM);
  assign w_next_count = r_count + CNT_W'(1);

  approx_sat_add #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_sat_add (
    .i_acc  (r_acc),
    .i_prod (prod_data),
    .o_sum  (w_sum),
    .o_ovf  (w_ovf)
  );

  // NOTE: non-blocking assignments so every branch below reads pre-edge register values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_trunc <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_start) begin
      r_acc   <= ACC_W'(prod_data);
      r_count <= CNT_W'(1);
      r_ovf   <= 1'b0;
      if (prod_last) begin
        r_state <= HOLD;
        r_trunc <= 1'b0;
        r_valid <= 1'b1;
      end else if (MAX_LEN == 1) begin
        r_state <= HOLD;
        r_trunc <= 1'b1;
        r_valid <= 1'b1;
      end else begin
        r_state <= ACCUM;
        r_trunc <= 1'b0;
        r_valid <= 1'b0;
      end
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_beat) begin
            r_acc   <= w_sum;
            r_count <= w_next_count;
            r_ovf   <= r_ovf | w_ovf;
            // An explicit last wins over the length limit, leaving truncated clear.
            if (prod_last) begin
              r_state <= HOLD;
              r_valid <= 1'b1;
            end else if (w_next_count == CNT_W'(MAX_LEN)) begin
              r_state <= HOLD;
              r_trunc <= 1'b1;
              r_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (w_consume) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign acc_valid     = r_valid;
  assign acc_data      = r_acc;
  assign acc_count     = r_count;
  assign acc_overflow  = r_ovf;
  assign acc_truncated = r_trunc;

endmodule

// File: tb/tb_approx_prod_accumulator.sv
// Directed bench for approx_prod_accumulator: a default instance, a narrow
// ACC_W=18 instance and a MAX_LEN=4 instance share one stimulus stream.
module tb_approx_prod_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prod_valid = 1'b0;
  logic [15:0] prod_data = '0;
  logic        prod_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        rdy0, rdy1, rdy2;
  logic        val0, val1, val2;
  logic [23:0] dat0;
  logic [17:0] dat1;
  logic [23:0] dat2;
  logic [8:0]  cnt0, cnt1;
  logic [2:0]  cnt2;
  logic        ovf0, ovf1, ovf2;
  logic        trc0, trc1, trc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  approx_prod_accumulator dut (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_data(prod_data),
    .prod_last(prod_last), .prod_ready(rdy0), .acc_valid(val0), .acc_data(dat0),
    .acc_count(cnt0), .acc_overflow(ovf0), .acc_truncated(trc0), .out_ready(out_ready)
  );

  approx_prod_accumulator #(.ACC_W(18)) dut_w18 (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_data(prod_data),
    .prod_last(prod_last), .prod_ready(rdy1), .acc_valid(val1), .acc_data(dat1),
    .acc_count(cnt1), .acc_overflow(ovf1), .acc_truncated(trc1), .out_ready(out_ready)
  );

  approx_prod_accumulator #(.MAX_LEN(4)) dut_m4 (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_data(prod_data),
    .prod_last(prod_last), .prod_ready(rdy2), .acc_valid(val2), .acc_data(dat2),
    .acc_count(cnt2), .acc_overflow(ovf2), .acc_truncated(trc2), .out_ready(out_ready)
  );

  typedef struct {
    int          sel;
    int          n;
    logic [15:0] d [5];
    bit          last;
    logic [31:0] e_data;
    logic [31:0] e_count;
    bit          e_ovf;
    bit          e_trunc;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    prod_valid = 1'b0;
    prod_last = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic beat(input logic [15:0] d, input bit last);
    prod_valid = 1'b1;
    prod_data = d;
    prod_last = last;
    tick();
    prod_valid = 1'b0;
    prod_last = 1'b0;
  endtask

  task automatic set_vec(input int idx, input int sel, input int n,
                         input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                         input logic [15:0] d, input logic [15:0] e, input bit last,
                         input logic [31:0] e_data, input logic [31:0] e_count,
                         input bit e_ovf, input bit e_trunc);
    vecs[idx].sel = sel;
    vecs[idx].n = n;
    vecs[idx].d[0] = a;
    vecs[idx].d[1] = b;
    vecs[idx].d[2] = c;
    vecs[idx].d[3] = d;
    vecs[idx].d[4] = e;
    vecs[idx].last = last;
    vecs[idx].e_data = e_data;
    vecs[idx].e_count = e_count;
    vecs[idx].e_ovf = e_ovf;
    vecs[idx].e_trunc = e_trunc;
  endtask

  function automatic logic [31:0] g_val(input int s);
    case (s)
      0: return 32'(val0);
      1: return 32'(val1);
      default: return 32'(val2);
    endcase
  endfunction

  function automatic logic [31:0] g_data(input int s);
    case (s)
      0: return 32'(dat0);
      1: return 32'(dat1);
      default: return 32'(dat2);
    endcase
  endfunction

  function automatic logic [31:0] g_cnt(input int s);
    case (s)
      0: return 32'(cnt0);
      1: return 32'(cnt1);
      default: return 32'(cnt2);
    endcase
  endfunction

  function automatic logic [31:0] g_ovf(input int s);
    case (s)
      0: return 32'(ovf0);
      1: return 32'(ovf1);
      default: return 32'(ovf2);
    endcase
  endfunction

  function automatic logic [31:0] g_trc(input int s);
    case (s)
      0: return 32'(trc0);
      1: return 32'(trc1);
      default: return 32'(trc2);
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_vec(0, 0, 3, 100, 200, 300, 0, 0, 1, 600, 3, 0, 0);
    set_vec(1, 0, 1, 16'hFFFF, 0, 0, 0, 0, 1, 32'h00FFFF, 1, 0, 0);
    set_vec(2, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    set_vec(3, 0, 5, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 32'h4FFFB, 5, 0, 0);
    set_vec(4, 1, 5, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 32'h3FFFF, 5, 1, 0);
    set_vec(5, 1, 5, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3, 1, 32'h3FFFF, 5, 0, 0);
    set_vec(6, 1, 5, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4, 1, 32'h3FFFF, 5, 1, 0);
    set_vec(7, 2, 4, 1, 1, 1, 1, 0, 1, 4, 4, 0, 0);
    set_vec(8, 2, 4, 1, 2, 3, 4, 0, 0, 10, 4, 0, 1);

    // Reset state, sampled while reset is still asserted.
    rst = 1'b1;
    tick();
    check("rst_valid", 32'(val0), 0);
    check("rst_data", 32'(dat0), 0);
    check("rst_count", 32'(cnt0), 0);
    check("rst_ovf", 32'(ovf0), 0);
    check("rst_trunc", 32'(trc0), 0);
    check("rst_ready", 32'(rdy0), 1);
    rst = 1'b0;

    // Table of complete runs, each followed by one consume cycle.
    out_ready = 1'b1;
    for (int v = 0; v < 9; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].n; i++) begin
        beat(vecs[v].d[i], vecs[v].last && (i == vecs[v].n - 1));
      end
      check($sformatf("v%0d_valid", v), g_val(vecs[v].sel), 1);
      check($sformatf("v%0d_data", v), g_data(vecs[v].sel), vecs[v].e_data);
      check($sformatf("v%0d_count", v), g_cnt(vecs[v].sel), vecs[v].e_count);
      check($sformatf("v%0d_ovf", v), g_ovf(vecs[v].sel), 32'(vecs[v].e_ovf));
      check($sformatf("v%0d_trunc", v), g_trc(vecs[v].sel), 32'(vecs[v].e_trunc));
      tick();
      check($sformatf("v%0d_consumed", v), g_val(vecs[v].sel), 0);
    end

    // Backpressure in HOLD, then a back-to-back run on release.
    do_reset();
    beat(10, 0);
    beat(20, 1);
    check("bp_valid", 32'(val0), 1);
    check("bp_data", 32'(dat0), 30);
    out_ready = 1'b0;
    prod_valid = 1'b1;
    prod_data = 7;
    prod_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_ready_%0d", k), 32'(rdy0), 0);
      tick();
      check($sformatf("bp_hold_valid_%0d", k), 32'(val0), 1);
      check($sformatf("bp_hold_data_%0d", k), 32'(dat0), 30);
      check($sformatf("bp_hold_count_%0d", k), 32'(cnt0), 2);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(rdy0), 1);
    tick();
    prod_valid = 1'b0;
    prod_last = 1'b0;
    check("b2b_valid", 32'(val0), 1);
    check("b2b_data", 32'(dat0), 7);
    check("b2b_count", 32'(cnt0), 1);
    tick();
    check("b2b_consumed", 32'(val0), 0);

    // Length limit of 4: the fifth beat waits until the truncated result is consumed.
    out_ready = 1'b0;
    do_reset();
    beat(1, 0);
    beat(2, 0);
    beat(3, 0);
    beat(4, 0);
    check("m4_valid", 32'(val2), 1);
    check("m4_data", 32'(dat2), 10);
    check("m4_count", 32'(cnt2), 4);
    check("m4_trunc", 32'(trc2), 1);
    prod_valid = 1'b1;
    prod_data = 5;
    prod_last = 1'b0;
    #1;
    check("m4_stall_ready", 32'(rdy2), 0);
    tick();
    check("m4_stall_data", 32'(dat2), 10);
    check("m4_stall_count", 32'(cnt2), 4);
    out_ready = 1'b1;
    tick();
    check("m4_new_valid", 32'(val2), 0);
    check("m4_new_data", 32'(dat2), 5);
    check("m4_new_count", 32'(cnt2), 1);
    check("m4_new_trunc", 32'(trc2), 0);
    beat(0, 1);
    check("m4_end_valid", 32'(val2), 1);
    check("m4_end_data", 32'(dat2), 5);
    check("m4_end_count", 32'(cnt2), 2);
    tick();

    // Idle cycles mid-run hold state; reset mid-run discards the partial sum.
    do_reset();
    beat(5, 0);
    beat(6, 0);
    prod_data = 16'hFFFF;
    prod_last = 1'b1;
    tick();
    prod_last = 1'b0;
    check("idle_valid", 32'(val0), 0);
    check("idle_data", 32'(dat0), 11);
    check("idle_count", 32'(cnt0), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", 32'(val0), 0);
    check("midrst_data", 32'(dat0), 0);
    check("midrst_count", 32'(cnt0), 0);
    check("midrst_ready", 32'(rdy0), 1);
    beat(9, 1);
    check("after_rst_valid", 32'(val0), 1);
    check("after_rst_data", 32'(dat0), 9);
    check("after_rst_count", 32'(cnt0), 1);
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("holdrst_valid", 32'(val0), 0);
    check("holdrst_data", 32'(dat0), 0);
    out_ready = 1'b1;

    // Full-length runs on the default instance: limit reached with and without last.
    for (int t = 0; t < 2; t++) begin
      do_reset();
      for (int i = 0; i < 256; i++) begin
        beat(1, (t == 1) && (i == 255));
      end
      check($sformatf("max%0d_valid", t), 32'(val0), 1);
      check($sformatf("max%0d_data", t), 32'(dat0), 256);
      check($sformatf("max%0d_count", t), 32'(cnt0), 256);
      check($sformatf("max%0d_trunc", t), 32'(trc0), (t == 0) ? 32'd1 : 32'd0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
